// File: rtl/gemma_acc_pkg.sv
// Shared constants and helpers for the accumulator output path.
// Holds the int8 limits, lane count and datapath widths used by the requant/pack stages.
package gemma_acc_pkg;

    localparam int INT8_MAX  = 127;
    localparam int INT8_MIN  = -128;
    localparam int OUT_LANES = 4;
    localparam int SHIFT_W   = 5;
    localparam int SCALE_W   = 16;
    localparam int PROD_W    = 49;

    typedef logic signed [PROD_W-1:0] prod_t;

    // Clamp a wide signed value into the int8 range and return its two's complement byte.
    function automatic logic [7:0] satInt8(input prod_t v);
        logic [7:0] result;
        if (v > prod_t'(INT8_MAX)) begin
            result = 8'(INT8_MAX);
        end else if (v < prod_t'(INT8_MIN)) begin
            result = 8'(INT8_MIN);
        end else begin
            result = v[7:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/output_requant_lane.sv
// Multiply / round / shift / saturate stages (S1 and S2) of the output requantizer.
// Optional round-half-up is enabled by defining OUTPUT_REQUANT_ROUND_EN; otherwise the shift truncates.
module output_requant_lane
    import gemma_acc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                valid_i,
    input  logic signed [31:0]  data_i,
    input  logic                last_i,
    input  logic [SCALE_W-1:0]  scale_i,
    input  logic [SHIFT_W-1:0]  shift_i,
    output logic                valid_o,
    output logic [7:0]          byte_o,
    output logic                last_o,
    output logic                busy_o
);

    logic       s1Valid_q;
    logic       s1Last_q;
    prod_t      s1Prod_q;
    prod_t      prod_d;
    prod_t      dataExt;
    prod_t      scaleExt;

    logic       s2Valid_q;
    logic       s2Last_q;
    logic [7:0] s2Byte_q;
    logic [7:0] s2Byte_d;

    prod_t      rnd;
    prod_t      sum;
    prod_t      shifted;

    // Scale is unsigned, so it is zero-extended before the signed multiply.
    always_comb begin
        dataExt  = prod_t'(data_i);
        scaleExt = prod_t'({1'b0, scale_i});
        prod_d   = dataExt * scaleExt;
    end

    always_comb begin
`ifdef OUTPUT_REQUANT_ROUND_EN
        rnd = (shift_i != '0) ? (prod_t'(1) << (shift_i - SHIFT_W'(1))) : '0;
`else
        rnd = '0;
`endif
        sum      = s1Prod_q + rnd;
        shifted  = sum >>> shift_i;
        s2Byte_d = satInt8(shifted);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Last_q  <= 1'b0;
            s1Prod_q  <= '0;
            s2Valid_q <= 1'b0;
            s2Last_q  <= 1'b0;
            s2Byte_q  <= '0;
        end else if (en_i) begin
            s1Valid_q <= valid_i;
            s1Last_q  <= valid_i & last_i;
            s1Prod_q  <= prod_d;
            s2Valid_q <= s1Valid_q;
            s2Last_q  <= s1Last_q;
            s2Byte_q  <= s2Byte_d;
        end
    end

    assign valid_o = s2Valid_q;
    assign byte_o  = s2Byte_q;
    assign last_o  = s2Last_q;
    assign busy_o  = s1Valid_q | s2Valid_q;

endmodule

// File: rtl/output_requant_packer.sv
// Requantizes a stream of int32 results to int8 and packs four lanes per 32-bit output word.
// Rounding mode is selected at build time by OUTPUT_REQUANT_ROUND_EN (see output_requant_lane).
module output_requant_packer
    import gemma_acc_pkg::*;
#(
    parameter int LANES = OUT_LANES
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_data,
    input  logic                   in_last,
    input  logic [SCALE_W-1:0]     scale,
    input  logic [SHIFT_W-1:0]     shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*LANES-1:0]     out_data,
    output logic [LANES-1:0]       out_strb,
    output logic                   out_last,
    output logic                   busy
);

    localparam int IDX_W = $clog2(LANES);
    typedef logic [IDX_W-1:0] idx_t;

    logic               adv;
    logic               s2Valid;
    logic               s2Last;
    logic [7:0]         s2Byte;
    logic               laneBusy;

    idx_t               idx_q, idx_d;
    logic [8*LANES-1:0] partWord_q, partWord_d;
    logic [LANES-1:0]   partStrb_q, partStrb_d;
    logic [8*LANES-1:0] mergedWord;
    logic [LANES-1:0]   mergedStrb;

    logic               outValid_q, outValid_d;
    logic [8*LANES-1:0] outData_q, outData_d;
    logic [LANES-1:0]   outStrb_q, outStrb_d;
    logic               outLast_q, outLast_d;

    // A single advance signal freezes the whole pipeline whenever the output word is stuck.
    assign adv      = !outValid_q | out_ready;
    assign in_ready = adv;

    output_requant_lane u_lane (
        .clk     (clk),
        .rst     (rst),
        .en_i    (adv),
        .valid_i (in_valid),
        .data_i  (in_data),
        .last_i  (in_last),
        .scale_i (scale),
        .shift_i (shift),
        .valid_o (s2Valid),
        .byte_o  (s2Byte),
        .last_o  (s2Last),
        .busy_o  (laneBusy)
    );

    always_comb begin
        mergedWord                      = partWord_q;
        mergedWord[{idx_q, 3'b000} +: 8] = s2Byte;
        mergedStrb                      = partStrb_q | (LANES'(1) << idx_q);
    end

    // Packer: a word closes on the final lane or on a tile boundary, then the partial state restarts.
    always_comb begin
        idx_d      = idx_q;
        partWord_d = partWord_q;
        partStrb_d = partStrb_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outStrb_d  = outStrb_q;
        outLast_d  = outLast_q;
        if (adv) begin
            outValid_d = 1'b0;
            if (s2Valid) begin
                if ((idx_q == idx_t'(LANES - 1)) || s2Last) begin
                    outValid_d = 1'b1;
                    outData_d  = mergedWord;
                    outStrb_d  = mergedStrb;
                    outLast_d  = s2Last;
                    partWord_d = '0;
                    partStrb_d = '0;
                    idx_d      = '0;
                end else begin
                    partWord_d = mergedWord;
                    partStrb_d = mergedStrb;
                    idx_d      = idx_q + idx_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            partWord_q <= '0;
            partStrb_q <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outStrb_q  <= '0;
            outLast_q  <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            partWord_q <= partWord_d;
            partStrb_q <= partStrb_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outStrb_q  <= outStrb_d;
            outLast_q  <= outLast_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_strb  = outStrb_q;
    assign out_last  = outLast_q;
    assign busy      = laneBusy | (|partStrb_q) | outValid_q;

endmodule

// File: tb/tb_output_requant_packer.sv
// Scoreboard bench for output_requant_packer: the driver queues expected words, a monitor pops and compares them.
// Expected rounding results follow OUTPUT_REQUANT_ROUND_EN when the bench is built with it.
module tb_output_requant_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        out_last;
    logic        busy;

    word_t expQ[$];
    int    vectorCount = 0;
    int    missCount   = 0;
    int    stallCycles = 0;
    logic  sawStall    = 1'b0;
    logic  heldPrev    = 1'b0;
    word_t heldWord;
    word_t popped;

    output_requant_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .scale     (scale),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_strb  (out_strb),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present one element from just after a falling edge and hold it until a rising edge accepts it.
    task automatic applyStimulus(input logic [31:0] d, input logic l);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && waitCnt < 200) begin
            sawStall = 1'b1;
            @(negedge clk);
            #1;
            waitCnt++;
        end
        if (waitCnt >= 200) begin
            checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
    endtask

    task automatic goIdle();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pushWord(input logic [31:0] d, input logic [3:0] s, input logic l);
        word_t w;
        w.data = d;
        w.strb = s;
        w.last = l;
        expQ.push_back(w);
    endtask

    task automatic waitDrain(input string name);
        int cyc;
        cyc = 0;
        goIdle();
        while ((expQ.size() != 0 || busy) && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checkOutput(name, 64'(expQ.size() == 0 && !busy), 64'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"},  64'(in_ready),  64'd1);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_out_data"},  64'(out_data),  64'd0);
        checkOutput({tag, "_out_strb"},  64'(out_strb),  64'd0);
        checkOutput({tag, "_out_last"},  64'(out_last),  64'd0);
        checkOutput({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        scale     = 16'd1;
        shift     = 5'd0;
        #2;
        checkResetValues("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        fork
            begin
                // Packing: lane 3 coincides with last.
                pushWord(32'h04030201, 4'hF, 1'b1);
                applyStimulus(32'd1, 1'b0);
                applyStimulus(32'd2, 1'b0);
                applyStimulus(32'd3, 1'b0);
                applyStimulus(32'd4, 1'b1);
                waitDrain("drain_pack");

                // Rounding vs truncation.
                shift = 5'd3;
`ifdef OUTPUT_REQUANT_ROUND_EN
                pushWord(32'h017D837E, 4'hF, 1'b1);
`else
                pushWord(32'h007D827D, 4'hF, 1'b1);
`endif
                applyStimulus(32'd1004, 1'b0);
                applyStimulus(-32'sd1004, 1'b0);
                applyStimulus(32'd1000, 1'b0);
                applyStimulus(32'd7, 1'b1);
                waitDrain("drain_round");

                // Saturation at both ends of int8.
                scale = 16'd3;
                shift = 5'd0;
                pushWord(32'h007E807F, 4'hF, 1'b1);
                applyStimulus(32'd100, 1'b0);
                applyStimulus(-32'sd100, 1'b0);
                applyStimulus(32'd42, 1'b0);
                applyStimulus(32'd0, 1'b1);
                waitDrain("drain_sat");

                // Partial flush, then a one-element tile starting back at lane 0.
                scale = 16'd1;
                pushWord(32'h00070605, 4'h7, 1'b1);
                pushWord(32'h00000008, 4'h1, 1'b1);
                applyStimulus(32'd5, 1'b0);
                applyStimulus(32'd6, 1'b0);
                applyStimulus(32'd7, 1'b1);
                applyStimulus(32'd8, 1'b1);
                waitDrain("drain_partial");

                // Backpressure: 16 elements -40,-35,...,35 with a 10-cycle stall mid-stream.
                pushWord(32'hE7E2DDD8, 4'hF, 1'b0);
                pushWord(32'hFBF6F1EC, 4'hF, 1'b0);
                pushWord(32'h0F0A0500, 4'hF, 1'b0);
                pushWord(32'h231E1914, 4'hF, 1'b1);
                sawStall = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    if (i == 6) stallCycles = 10;
                    applyStimulus(32'(i * 5 - 40), i == 15);
                end
                waitDrain("drain_backpressure");
                checkOutput("in_ready_dropped", 64'(sawStall), 64'd1);

                // Reset in the middle of a tile drops the in-flight elements.
                applyStimulus(32'd50, 1'b0);
                applyStimulus(32'd51, 1'b0);
                @(negedge clk);
                #1;
                in_valid = 1'b0;
                rst      = 1'b1;
                #1;
                checkResetValues("midreset");
                @(negedge clk);
                #1;
                rst = 1'b0;
                pushWord(32'h0C0B0A09, 4'hF, 1'b1);
                applyStimulus(32'd9, 1'b0);
                applyStimulus(32'd10, 1'b0);
                applyStimulus(32'd11, 1'b0);
                applyStimulus(32'd12, 1'b1);
                waitDrain("drain_after_reset");
                repeat (5) @(negedge clk);
            end
            begin
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        heldPrev  = 1'b0;
                        out_ready = 1'b1;
                        continue;
                    end
                    if (heldPrev) begin
                        checkOutput("hold_stable", {26'd0, out_valid, out_data, out_strb, out_last},
                                    {26'd0, 1'b1, heldWord});
                    end
                    if (stallCycles > 0) begin
                        out_ready = 1'b0;
                        stallCycles--;
                    end else begin
                        out_ready = 1'b1;
                    end
                    if (out_valid && out_ready) begin
                        if (expQ.size() == 0) begin
                            vectorCount++;
                            missCount++;
                            $display("[TB] FAIL unexpected_word: got %0h/%0h/%0b, expected no word",
                                     out_data, out_strb, out_last);
                        end else begin
                            popped = expQ.pop_front();
                            checkOutput("word", 64'({out_data, out_strb, out_last}), 64'(popped));
                        end
                    end
                    heldPrev = out_valid && !out_ready;
                    heldWord = {out_data, out_strb, out_last};
                end
            end
        join_any
        disable fork;

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
